// File: rtl/vx_tcu_csr_stage_if.sv
// Bundle of CSR write, ack, busy-tracking and config lookup signals between
// the TCU CSR dispatch side (master) and the per-block config stage (slave).
interface vx_tcu_csr_stage_if #(
  parameter int NUM_WARPS = 4,
  parameter int CSR_COUNT = 4,
  parameter int DATA_W    = 32
);
  localparam int WID_W  = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
  localparam int ADDR_W = (CSR_COUNT > 1) ? $clog2(CSR_COUNT) : 1;

  // CSR write request
  logic                        csr_valid;
  logic                        csr_ready;
  logic [WID_W-1:0]            csr_wid;
  logic [ADDR_W-1:0]           csr_addr;
  logic [DATA_W-1:0]           csr_wdata;

  // Commit acknowledge
  logic                        csr_ack_valid;
  logic                        csr_ack_ready;
  logic [WID_W-1:0]            csr_ack_wid;

  // In-flight op tracking
  logic                        busy_set;
  logic [WID_W-1:0]            busy_set_wid;
  logic                        busy_clr;
  logic [WID_W-1:0]            busy_clr_wid;

  // Config lookup
  logic                        cfg_req_valid;
  logic [WID_W-1:0]            cfg_req_wid;
  logic                        cfg_rsp_valid;
  logic [CSR_COUNT*DATA_W-1:0] cfg_rsp_data;

  // Status
  logic [NUM_WARPS-1:0]        cfg_pending;
  logic                        err;

  modport master (
    output csr_valid, csr_wid, csr_addr, csr_wdata, csr_ack_ready,
           busy_set, busy_set_wid, busy_clr, busy_clr_wid,
           cfg_req_valid, cfg_req_wid,
    input  csr_ready, csr_ack_valid, csr_ack_wid,
           cfg_rsp_valid, cfg_rsp_data, cfg_pending, err
  );

  modport slave (
    input  csr_valid, csr_wid, csr_addr, csr_wdata, csr_ack_ready,
           busy_set, busy_set_wid, busy_clr, busy_clr_wid,
           cfg_req_valid, cfg_req_wid,
    output csr_ready, csr_ack_valid, csr_ack_wid,
           cfg_rsp_valid, cfg_rsp_data, cfg_pending, err
  );
endinterface

// File: rtl/vx_tcu_csr_stage.sv
// Per-block TCU configuration stage: per-warp config registers, per-warp
// in-flight op counters, CSR writes deferred until the target warp drains,
// and a one-cycle registered config lookup port for the tensor PE.
module vx_tcu_csr_stage #(
  parameter int NUM_WARPS = 4,
  parameter int CSR_COUNT = 4,
  parameter int DATA_W    = 32,
  parameter int CNT_W     = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  vx_tcu_csr_stage_if.slave       bus
);
  localparam int WID_W  = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
  localparam int ADDR_W = (CSR_COUNT > 1) ? $clog2(CSR_COUNT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    ACK   = 2'd2
  } state_e;

  // One-hot warp decode; an out-of-range wid decodes to all zeros.
  function automatic logic [NUM_WARPS-1:0] wid_onehot(input logic [WID_W-1:0] wid);
    logic [NUM_WARPS-1:0] v;
    v = '0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      if (int'(wid) == w) v[w] = 1'b1;
    end
    return v;
  endfunction

  // One-hot register decode; an out-of-range addr decodes to all zeros.
  function automatic logic [CSR_COUNT-1:0] addr_onehot(input logic [ADDR_W-1:0] addr);
    logic [CSR_COUNT-1:0] v;
    v = '0;
    for (int a = 0; a < CSR_COUNT; a++) begin
      if (int'(addr) == a) v[a] = 1'b1;
    end
    return v;
  endfunction

  // Saturating up/down counter step. Returns {error, next_count}: a decrement
  // at zero or an increment at the maximum holds the count and flags error.
  function automatic logic [CNT_W:0] cnt_next(input logic [CNT_W-1:0] cur,
                                              input logic inc,
                                              input logic dec);
    logic [CNT_W:0] r;
    r = {1'b0, cur};
    if (inc && !dec) begin
      if (cur == CNT_MAX) r = {1'b1, cur};
      else                r = {1'b0, cur + 1'b1};
    end else if (dec && !inc) begin
      if (cur == '0)      r = {1'b1, cur};
      else                r = {1'b0, cur - 1'b1};
    end
    return r;
  endfunction

  // Control state
  state_e               state_q;
  logic                 ready_q;
  logic                 ack_valid_q;
  logic [WID_W-1:0]     ack_wid_q;
  logic [NUM_WARPS-1:0] pending_q;

  // Held CSR write
  logic [WID_W-1:0]     hold_wid_q;
  logic [ADDR_W-1:0]    hold_addr_q;
  logic [DATA_W-1:0]    hold_data_q;

  // In-flight counters and sticky error
  logic [CNT_W-1:0]     inflight_q [NUM_WARPS];
  logic [CNT_W-1:0]     inflight_d [NUM_WARPS];
  logic [CNT_W:0]       cnt_res    [NUM_WARPS];
  logic                 err_q;
  logic                 err_d;

  // Config storage and lookup response
  logic [DATA_W-1:0]           cfg_q [NUM_WARPS][CSR_COUNT];
  logic                        rsp_valid_q;
  logic [CSR_COUNT*DATA_W-1:0] rsp_data_q;
  logic [CSR_COUNT*DATA_W-1:0] rsp_data_d;

  // Decodes
  logic [NUM_WARPS-1:0] set_oh;
  logic [NUM_WARPS-1:0] clr_oh;
  logic [NUM_WARPS-1:0] hold_wid_oh;
  logic [CSR_COUNT-1:0] hold_addr_oh;
  logic [NUM_WARPS-1:0] req_wid_oh;
  logic                 hold_idle;
  logic                 cfg_we;

  assign set_oh       = bus.busy_set ? wid_onehot(bus.busy_set_wid) : '0;
  assign clr_oh       = bus.busy_clr ? wid_onehot(bus.busy_clr_wid) : '0;
  assign hold_wid_oh  = wid_onehot(hold_wid_q);
  assign hold_addr_oh = addr_onehot(hold_addr_q);
  assign req_wid_oh   = wid_onehot(bus.cfg_req_wid);

  // Held warp has no ops in flight (registered count only); an out-of-range
  // warp has nothing to drain.
  always_comb begin
    hold_idle = 1'b1;
    for (int w = 0; w < NUM_WARPS; w++) begin
      if (hold_wid_oh[w] && (inflight_q[w] != '0)) hold_idle = 1'b0;
    end
  end

  assign cfg_we = (state_q == DRAIN) && hold_idle;

  // CSR write sequencing: accept, wait for drain, then hold the ack until taken.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      ready_q     <= 1'b1;
      ack_valid_q <= 1'b0;
      ack_wid_q   <= '0;
      pending_q   <= '0;
      hold_wid_q  <= '0;
      hold_addr_q <= '0;
      hold_data_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.csr_valid && ready_q) begin
            hold_wid_q  <= bus.csr_wid;
            hold_addr_q <= bus.csr_addr;
            hold_data_q <= bus.csr_wdata;
            pending_q   <= wid_onehot(bus.csr_wid);
            ready_q     <= 1'b0;
            state_q     <= DRAIN;
          end
        end
        DRAIN: begin
          if (hold_idle) begin
            pending_q   <= '0;
            ack_valid_q <= 1'b1;
            ack_wid_q   <= hold_wid_q;
            state_q     <= ACK;
          end
        end
        ACK: begin
          if (bus.csr_ack_ready) begin
            ack_valid_q <= 1'b0;
            ready_q     <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          ack_valid_q <= 1'b0;
          pending_q   <= '0;
          ready_q     <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  // Next in-flight counts and error from this cycle's set/clr pulses.
  always_comb begin
    err_d = err_q;
    for (int w = 0; w < NUM_WARPS; w++) begin
      cnt_res[w]    = cnt_next(inflight_q[w], set_oh[w], clr_oh[w]);
      inflight_d[w] = cnt_res[w][CNT_W-1:0];
      err_d         = err_d | cnt_res[w][CNT_W];
    end
  end

  // In-flight counters and sticky over/underflow flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int w = 0; w < NUM_WARPS; w++) inflight_q[w] <= '0;
      err_q <= 1'b0;
    end else begin
      for (int w = 0; w < NUM_WARPS; w++) inflight_q[w] <= inflight_d[w];
      err_q <= err_d;
    end
  end

  // Config registers; an out-of-range target matches no entry and is dropped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        for (int a = 0; a < CSR_COUNT; a++) cfg_q[w][a] <= '0;
      end
    end else if (cfg_we) begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        for (int a = 0; a < CSR_COUNT; a++) begin
          if (hold_wid_oh[w] && hold_addr_oh[a]) cfg_q[w][a] <= hold_data_q;
        end
      end
    end
  end

  // Lookup mux over the current (pre-write) config; out-of-range warp reads zero.
  always_comb begin
    rsp_data_d = '0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      for (int a = 0; a < CSR_COUNT; a++) begin
        if (req_wid_oh[w]) rsp_data_d[a*DATA_W +: DATA_W] = cfg_q[w][a];
      end
    end
  end

  // Registered lookup response, one cycle after the request, never stalls.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      rsp_valid_q <= bus.cfg_req_valid;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign bus.csr_ready     = ready_q;
  assign bus.csr_ack_valid = ack_valid_q;
  assign bus.csr_ack_wid   = ack_wid_q;
  assign bus.cfg_pending   = pending_q;
  assign bus.cfg_rsp_valid = rsp_valid_q;
  assign bus.cfg_rsp_data  = rsp_data_q;
  assign bus.err           = err_q;

endmodule

// File: tb/tb_vx_tcu_csr_stage.sv
// Directed bench for vx_tcu_csr_stage: CSR write latency, drain stall,
// ack backpressure, counter edges, lookup collision and async reset.
module tb_vx_tcu_csr_stage;
  localparam int NW = 4;
  localparam int CC = 4;
  localparam int DW = 32;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  vx_tcu_csr_stage_if #(.NUM_WARPS(NW), .CSR_COUNT(CC), .DATA_W(DW)) bus ();

  vx_tcu_csr_stage #(.NUM_WARPS(NW), .CSR_COUNT(CC), .DATA_W(DW), .CNT_W(CW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    bus.csr_valid     = 1'b0;
    bus.csr_wid       = '0;
    bus.csr_addr      = '0;
    bus.csr_wdata     = '0;
    bus.csr_ack_ready = 1'b0;
    bus.busy_set      = 1'b0;
    bus.busy_set_wid  = '0;
    bus.busy_clr      = 1'b0;
    bus.busy_clr_wid  = '0;
    bus.cfg_req_valid = 1'b0;
    bus.cfg_req_wid   = '0;

    // Reset values
    step();
    step();
    check("rst_ready",     bus.csr_ready,     1);
    check("rst_ack_valid", bus.csr_ack_valid, 0);
    check("rst_ack_wid",   bus.csr_ack_wid,   0);
    check("rst_rsp_valid", bus.cfg_rsp_valid, 0);
    check("rst_rsp_data",  bus.cfg_rsp_data,  0);
    check("rst_pending",   bus.cfg_pending,   0);
    check("rst_err",       bus.err,           0);
    reset_n = 1'b1;

    // Idle write to warp 1 addr 2, then ack backpressure for 5 cycles
    bus.csr_valid = 1'b1; bus.csr_wid = 2'd1; bus.csr_addr = 2'd2; bus.csr_wdata = 32'hDEAD_BEEF;
    step();
    bus.csr_valid = 1'b0;
    check("w1_ready_low",  bus.csr_ready,     0);
    check("w1_pending",    bus.cfg_pending,   4'b0010);
    check("w1_no_ack_c1",  bus.csr_ack_valid, 0);
    step();
    check("w1_ack_c2",     bus.csr_ack_valid, 1);
    check("w1_ack_wid",    bus.csr_ack_wid,   1);
    check("w1_pending_clr", bus.cfg_pending,  0);
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_ack_valid", bus.csr_ack_valid, 1);
      check("bp_ack_wid",   bus.csr_ack_wid,   1);
      check("bp_ready",     bus.csr_ready,     0);
    end
    bus.csr_ack_ready = 1'b1;
    step();
    bus.csr_ack_ready = 1'b0;
    check("bp_ack_done",  bus.csr_ack_valid, 0);
    check("bp_ready_back", bus.csr_ready,    1);
    bus.cfg_req_valid = 1'b1; bus.cfg_req_wid = 2'd1;
    step();
    bus.cfg_req_valid = 1'b0;
    check("w1_rsp_valid", bus.cfg_rsp_valid, 1);
    check("w1_rsp_data",  bus.cfg_rsp_data,  {32'h0, 32'hDEAD_BEEF, 64'h0});
    step();
    check("w1_rsp_valid_drop", bus.cfg_rsp_valid, 0);

    // Minimum latency with ack_ready already high: warp 2 addr 1
    bus.csr_ack_ready = 1'b1;
    bus.csr_valid = 1'b1; bus.csr_wid = 2'd2; bus.csr_addr = 2'd1; bus.csr_wdata = 32'h1234_5678;
    step();
    bus.csr_valid = 1'b0;
    check("lat_no_ack_c1", bus.csr_ack_valid, 0);
    step();
    check("lat_ack_c2",    bus.csr_ack_valid, 1);
    check("lat_ack_wid",   bus.csr_ack_wid,   2);
    step();
    check("lat_ready_c3",  bus.csr_ready,     1);
    check("lat_ack_gone",  bus.csr_ack_valid, 0);
    bus.csr_ack_ready = 1'b0;

    // Drain stall: three ops on warp 0, then a write to warp 0
    bus.busy_set = 1'b1; bus.busy_set_wid = 2'd0;
    step(); step(); step();
    bus.busy_set = 1'b0;
    bus.csr_valid = 1'b1; bus.csr_wid = 2'd0; bus.csr_addr = 2'd0; bus.csr_wdata = 32'h1111_1111;
    step();
    bus.csr_valid = 1'b0;
    check("drn_pending",   bus.cfg_pending, 4'b0001);
    step(); step();
    check("drn_held_ack",  bus.csr_ack_valid, 0);
    check("drn_held_pend", bus.cfg_pending,   4'b0001);
    bus.busy_clr = 1'b1; bus.busy_clr_wid = 2'd0;
    step(); step();
    check("drn_cnt1_ack",  bus.csr_ack_valid, 0);
    step();
    bus.busy_clr = 1'b0;
    check("drn_cnt0_ack",  bus.csr_ack_valid, 0);
    check("drn_cnt0_pend", bus.cfg_pending,   4'b0001);
    step();
    check("drn_ack",       bus.csr_ack_valid, 1);
    check("drn_ack_wid",   bus.csr_ack_wid,   0);
    check("drn_pend_clr",  bus.cfg_pending,   0);
    bus.csr_ack_ready = 1'b1;
    step();
    bus.csr_ack_ready = 1'b0;
    check("drn_ready",     bus.csr_ready, 1);

    // Lookup collides with the write edge: old value, then new value
    bus.csr_valid = 1'b1; bus.csr_wid = 2'd1; bus.csr_addr = 2'd2; bus.csr_wdata = 32'hCAFE_F00D;
    step();
    bus.csr_valid = 1'b0;
    bus.cfg_req_valid = 1'b1; bus.cfg_req_wid = 2'd1;
    step();
    check("col_old",       bus.cfg_rsp_data, {32'h0, 32'hDEAD_BEEF, 64'h0});
    check("col_ack",       bus.csr_ack_valid, 1);
    bus.csr_ack_ready = 1'b1;
    step();
    bus.csr_ack_ready = 1'b0;
    check("col_new",       bus.cfg_rsp_data, {32'h0, 32'hCAFE_F00D, 64'h0});
    check("col_ready",     bus.csr_ready, 1);
    bus.cfg_req_wid = 2'd0;
    step();
    check("lk_w0",         bus.cfg_rsp_data, {96'h0, 32'h1111_1111});
    bus.cfg_req_wid = 2'd2;
    step();
    bus.cfg_req_valid = 1'b0;
    check("lk_w2",         bus.cfg_rsp_data, {64'h0, 32'h1234_5678, 32'h0});

    // Counter edges on warp 2
    check("cnt_err_start", bus.err, 0);
    bus.busy_set = 1'b1; bus.busy_set_wid = 2'd2;
    step();
    bus.busy_clr = 1'b1; bus.busy_clr_wid = 2'd2;
    step();
    bus.busy_set = 1'b0;
    check("cnt_setclr_err", bus.err, 0);
    step();
    check("cnt_to_zero_err", bus.err, 0);
    step();
    bus.busy_clr = 1'b0;
    check("cnt_underflow_err", bus.err, 1);
    step(); step();
    check("cnt_err_sticky", bus.err, 1);

    // Mid-cycle reset clears the sticky error
    #2 reset_n = 1'b0;
    #1;
    check("rst2_err", bus.err, 0);
    reset_n = 1'b1;
    step();

    // Saturation on warp 3: sixteen sets, count held at 15
    bus.busy_set = 1'b1; bus.busy_set_wid = 2'd3;
    for (int i = 0; i < 15; i++) step();
    check("sat_15_err", bus.err, 0);
    step();
    bus.busy_set = 1'b0;
    check("sat_16_err", bus.err, 1);
    bus.csr_valid = 1'b1; bus.csr_wid = 2'd3; bus.csr_addr = 2'd3; bus.csr_wdata = 32'hA5A5_A5A5;
    step();
    bus.csr_valid = 1'b0;
    bus.busy_clr = 1'b1; bus.busy_clr_wid = 2'd3;
    for (int i = 0; i < 14; i++) step();
    check("sat_cnt1_ack", bus.csr_ack_valid, 0);
    step();
    bus.busy_clr = 1'b0;
    check("sat_cnt0_ack", bus.csr_ack_valid, 0);
    step();
    check("sat_ack",      bus.csr_ack_valid, 1);
    check("sat_ack_wid",  bus.csr_ack_wid,   3);
    bus.csr_ack_ready = 1'b1;
    step();
    bus.csr_ack_ready = 1'b0;

    // Async reset while a write to warp 0 is draining
    bus.busy_set = 1'b1; bus.busy_set_wid = 2'd0;
    step();
    bus.busy_set = 1'b0;
    bus.csr_valid = 1'b1; bus.csr_wid = 2'd0; bus.csr_addr = 2'd1; bus.csr_wdata = 32'h0000_0055;
    bus.cfg_req_valid = 1'b1; bus.cfg_req_wid = 2'd3;
    step();
    bus.csr_valid = 1'b0;
    bus.cfg_req_valid = 1'b0;
    check("ar_pending",   bus.cfg_pending, 4'b0001);
    check("ar_rsp_valid", bus.cfg_rsp_valid, 1);
    check("ar_rsp_w3",    bus.cfg_rsp_data, {32'hA5A5_A5A5, 96'h0});
    step();
    check("ar_blocked",   bus.csr_ack_valid, 0);
    #2 reset_n = 1'b0;
    #1;
    check("ar_ready",     bus.csr_ready,     1);
    check("ar_ack_valid", bus.csr_ack_valid, 0);
    check("ar_ack_wid",   bus.csr_ack_wid,   0);
    check("ar_pend",      bus.cfg_pending,   0);
    check("ar_rsp_v",     bus.cfg_rsp_valid, 0);
    check("ar_rsp_d",     bus.cfg_rsp_data,  0);
    check("ar_err",       bus.err,           0);
    reset_n = 1'b1;
    bus.csr_ack_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("ar_no_ack",  bus.csr_ack_valid, 0);
    end
    bus.csr_ack_ready = 1'b0;
    bus.cfg_req_valid = 1'b1; bus.cfg_req_wid = 2'd1;
    step();
    bus.cfg_req_valid = 1'b0;
    check("ar_cfg_zero",  bus.cfg_rsp_data, 0);
    bus.csr_valid = 1'b1; bus.csr_wid = 2'd0; bus.csr_addr = 2'd0; bus.csr_wdata = 32'h0000_0077;
    step();
    bus.csr_valid = 1'b0;
    step();
    check("ar_cnt_zeroed_ack", bus.csr_ack_valid, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
